aer_output_arbiter: RTL and testbench

//  Parametrised address-event (AER) output stage for a spiking layer. Captures per-neuron

---
 rtl/aer_output_arbiter.sv | 117 +++++++++++
 tb/tb_aer_output_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/aer_output_arbiter.sv
// AER output stage: sticky per-neuron pending bits, fixed-priority or
// round-robin arbitration, one address event per cycle on a valid/ready
// link, a one-hot ack to the granted neuron and a saturating drop counter.
module aer_output_arbiter #(
   parameter int N_NEURONS   = 8,
   parameter int ADDR_W      = $clog2(N_NEURONS),
   parameter int ROUND_ROBIN = 0,
   parameter int DROP_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_NEURONS-1:0] spikes_in,
   output logic [N_NEURONS-1:0] acks_out,
   output logic                 event_valid,
   output logic [ADDR_W-1:0]    event_addr,
   input  logic                 event_ready,
   output logic                 spike_out,
   output logic [DROP_W-1:0]    drop_count,
   output logic                 overflow,
   input  logic                 clear_stats
);

   localparam int CNT_W = $clog2(N_NEURONS + 1);
   localparam int SUM_W = DROP_W + CNT_W;
   localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

   logic [N_NEURONS-1:0] pending_q, pending_d;
   logic [N_NEURONS-1:0] acks_q;
   logic                 valid_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [ADDR_W-1:0]    ptr_q, ptr_d;
   logic [DROP_W-1:0]    drop_q, drop_d;
   logic                 ovf_q;

   logic                 slot_free;
   logic                 win_found;
   logic [ADDR_W-1:0]    win_idx;
   logic                 grant;
   logic [N_NEURONS-1:0] grant_oh;
   logic [N_NEURONS-1:0] drop_vec;
   logic [CNT_W-1:0]     drop_n;
   logic [SUM_W-1:0]     drop_sum;
   int                   idx;

   // Output register can take a new event when empty or being drained.
   assign slot_free = !valid_q || event_ready;

   // Winner search: scan from the rr pointer (or from 0) with wrap-around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int j = 0; j < N_NEURONS; j++) begin
         idx = (ROUND_ROBIN != 0) ? int'(ptr_q) + j : j;
         if (idx >= N_NEURONS) idx = idx - N_NEURONS;
         if (!win_found && pending_q[idx]) begin
            win_found = 1'b1;
            win_idx   = ADDR_W'(idx);
         end
      end
   end

   // Grant decode, collision count and next-state for pending/pointer/counter.
   always_comb begin
      grant    = slot_free && win_found;
      grant_oh = '0;
      if (grant) grant_oh[win_idx] = 1'b1;
      // A spike landing on an already-pending bit is lost unless that bit is
      // being granted on this same edge (then it simply becomes the next event).
      drop_vec = spikes_in & pending_q & ~grant_oh;
      drop_n   = '0;
      for (int i = 0; i < N_NEURONS; i++) drop_n = drop_n + CNT_W'(drop_vec[i]);
      drop_sum  = SUM_W'(drop_q) + SUM_W'(drop_n);
      drop_d    = (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_W-1:0];
      pending_d = (pending_q & ~grant_oh) | spikes_in;
      if (int'(win_idx) == N_NEURONS - 1) ptr_d = '0;
      else                                ptr_d = win_idx + ADDR_W'(1);
   end

   // State update; the ack register is rewritten every cycle so it pulses once.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         acks_q    <= '0;
         valid_q   <= 1'b0;
         addr_q    <= '0;
         ptr_q     <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         acks_q    <= grant_oh;
         if (grant) begin
            valid_q <= 1'b1;
            addr_q  <= win_idx;
            ptr_q   <= ptr_d;
         end else if (event_ready) begin
            valid_q <= 1'b0;
         end
         if (clear_stats) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
         end else if (|drop_vec) begin
            drop_q <= drop_d;
            ovf_q  <= 1'b1;
         end
      end
   end

   assign acks_out    = acks_q;
   assign event_valid = valid_q;
   assign event_addr  = addr_q;
   assign drop_count  = drop_q;
   assign overflow    = ovf_q;
   assign spike_out   = (|pending_q) || valid_q;

endmodule

// File: tb/tb_aer_output_arbiter.sv
// Bench for aer_output_arbiter: one fixed-priority instance (8-bit drop
// counter) and one round-robin instance (2-bit drop counter) share stimulus
// and are compared every cycle against a behavioural model, plus directed
// constant checks for the key scenarios.
module tb_aer_output_arbiter;
   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] spikes = '0;
   logic       ready = 1'b1;
   logic       clear = 1'b0;

   logic [7:0] acks0, acks1;
   logic       valid0, valid1;
   logic [2:0] addr0, addr1;
   logic       sout0, sout1;
   logic [7:0] drop0;
   logic [1:0] drop1;
   logic       ovf0, ovf1;

   int checks = 0;
   int errors = 0;

   // behavioural model state, index 0 = fixed priority, 1 = round robin
   logic [7:0] m_pend [2];
   logic [7:0] m_acks [2];
   bit         m_valid[2];
   int         m_addr [2];
   int         m_ptr  [2];
   int         m_drop [2];
   bit         m_ovf  [2];
   int         dmax   [2];

   aer_output_arbiter #(.N_NEURONS(8), .ROUND_ROBIN(0), .DROP_W(8)) dut0 (
      .clk(clk), .rst(rst), .spikes_in(spikes), .acks_out(acks0),
      .event_valid(valid0), .event_addr(addr0), .event_ready(ready),
      .spike_out(sout0), .drop_count(drop0), .overflow(ovf0), .clear_stats(clear));

   aer_output_arbiter #(.N_NEURONS(8), .ROUND_ROBIN(1), .DROP_W(2)) dut1 (
      .clk(clk), .rst(rst), .spikes_in(spikes), .acks_out(acks1),
      .event_valid(valid1), .event_addr(addr1), .event_ready(ready),
      .spike_out(sout1), .drop_count(drop1), .overflow(ovf1), .clear_stats(clear));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge of the model, from the inputs presently applied.
   task automatic model_step();
      int  win, nd, i;
      bit  grant;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_pend[d] = '0; m_acks[d] = '0; m_valid[d] = 0; m_addr[d] = 0;
            m_ptr[d] = 0; m_drop[d] = 0; m_ovf[d] = 0;
         end else begin
            win = -1;
            for (int j = 0; j < N; j++) begin
               i = (d == 1) ? (m_ptr[d] + j) % N : j;
               if (win < 0 && m_pend[d][i]) win = i;
            end
            grant = (!m_valid[d] || ready) && (win >= 0);
            nd = 0;
            for (int k = 0; k < N; k++)
               if (spikes[k] && m_pend[d][k] && !(grant && k == win)) nd++;
            m_acks[d] = '0;
            if (grant) begin
               m_acks[d][win] = 1'b1;
               m_pend[d][win] = 1'b0;
               m_valid[d] = 1;
               m_addr[d]  = win;
               m_ptr[d]   = (win + 1) % N;
            end else if (m_valid[d] && ready) begin
               m_valid[d] = 0;
            end
            m_pend[d] = m_pend[d] | spikes;
            if (clear) begin
               m_drop[d] = 0; m_ovf[d] = 0;
            end else if (nd > 0) begin
               m_drop[d] = (m_drop[d] + nd > dmax[d]) ? dmax[d] : m_drop[d] + nd;
               m_ovf[d]  = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("m0_acks",  32'(acks0),  32'(m_acks[0]));
      chk("m0_valid", 32'(valid0), 32'(m_valid[0]));
      chk("m0_addr",  32'(addr0),  32'(m_addr[0]));
      chk("m0_busy",  32'(sout0),  32'((|m_pend[0]) || m_valid[0]));
      chk("m0_drop",  32'(drop0),  32'(m_drop[0]));
      chk("m0_ovf",   32'(ovf0),   32'(m_ovf[0]));
      chk("m1_acks",  32'(acks1),  32'(m_acks[1]));
      chk("m1_valid", 32'(valid1), 32'(m_valid[1]));
      chk("m1_addr",  32'(addr1),  32'(m_addr[1]));
      chk("m1_busy",  32'(sout1),  32'((|m_pend[1]) || m_valid[1]));
      chk("m1_drop",  32'(drop1),  32'(m_drop[1]));
      chk("m1_ovf",   32'(ovf1),   32'(m_ovf[1]));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      dmax[0] = 255; dmax[1] = 3;
      for (int d = 0; d < 2; d++) begin
         m_pend[d] = '0; m_acks[d] = '0; m_valid[d] = 0; m_addr[d] = 0;
         m_ptr[d] = 0; m_drop[d] = 0; m_ovf[d] = 0;
      end

      // reset held two cycles with all spikes asserted
      rst = 1'b1; spikes = 8'hFF; ready = 1'b1;
      step(); step();
      chk("rst_valid", 32'(valid0), 0);
      chk("rst_acks",  32'(acks0 | acks1), 0);
      chk("rst_busy",  32'(sout0 | sout1), 0);
      chk("rst_drop",  32'(drop0), 0);
      rst = 1'b0; spikes = 8'h00;
      step();
      chk("rel_busy", 32'(sout0 | sout1), 0);

      // latency: spike at t -> pending at t+1 -> event at t+2
      spikes = 8'h08; step();
      chk("lat_pend_valid", 32'(valid0), 0);
      chk("lat_pend_busy",  32'(sout0), 1);
      spikes = 8'h00; step();
      chk("lat_valid", 32'(valid0), 1);
      chk("lat_addr",  32'(addr0), 3);
      chk("lat_acks",  32'(acks0), 32'h08);
      step();
      chk("lat_acks_off", 32'(acks0), 0);
      chk("lat_idle",     32'(valid0), 0);

      // fixed priority drains 0,2,5,7; rr (ptr=4) drains 5,7,0,2
      spikes = 8'hA5; step();
      spikes = 8'h00;
      step(); chk("fp_a0", 32'(addr0), 0); chk("rr_a0", 32'(addr1), 5);
      step(); chk("fp_a1", 32'(addr0), 2); chk("rr_a1", 32'(addr1), 7);
      step(); chk("fp_a2", 32'(addr0), 5); chk("rr_a2", 32'(addr1), 0);
      step(); chk("fp_a3", 32'(addr0), 7); chk("rr_a3", 32'(addr1), 2);
      step(); chk("fp_done", 32'(valid0), 0);

      // continuous spikes on 0 and 1: rr alternates, fixed priority starves 1
      spikes = 8'h03; step();
      step(); chk("rr_alt0", 32'(addr1), 0); chk("fp_alt0", 32'(addr0), 0);
      step(); chk("rr_alt1", 32'(addr1), 1); chk("fp_alt1", 32'(addr0), 0);
      step(); chk("rr_alt2", 32'(addr1), 0);
      step(); chk("rr_alt3", 32'(addr1), 1);
      spikes = 8'h00;
      repeat (4) step();
      // grant on 7 moves the pointer to 0, so 0 beats 6
      spikes = 8'h80; step();
      spikes = 8'h00; step(); chk("rr_g7", 32'(addr1), 7);
      spikes = 8'h41; step();
      spikes = 8'h00; step(); chk("rr_wrap0", 32'(addr1), 0);
      step(); chk("rr_wrap6", 32'(addr1), 6);
      step();

      // backpressure: held event stays stable, repeat spike on 1 is dropped
      clear = 1'b1; step(); clear = 1'b0;
      ready = 1'b0; spikes = 8'h03; step();
      spikes = 8'h00; step();
      chk("bp_acks", 32'(acks0), 32'h01);
      for (int c = 0; c < 9; c++) begin
         spikes = (c == 4) ? 8'h02 : 8'h00;
         step();
         chk("bp_valid", 32'(valid0), 1);
         chk("bp_addr",  32'(addr0), 0);
         chk("bp_noack", 32'(acks0), 0);
      end
      chk("bp_drop0", 32'(drop0), 1);
      chk("bp_ovf0",  32'(ovf0), 1);
      chk("bp_drop1", 32'(drop1), 1);
      ready = 1'b1; step();
      chk("bp_next",  32'(addr0), 1);
      chk("bp_ack1",  32'(acks0), 32'h02);
      step();

      // saturation of the 2-bit counter and clear beating a simultaneous drop
      clear = 1'b1; step(); clear = 1'b0;
      ready = 1'b0; spikes = 8'hFF; step(); step();
      chk("sat_drop0", 32'(drop0), 7);
      chk("sat_drop1", 32'(drop1), 3);
      chk("sat_ovf1",  32'(ovf1), 1);
      clear = 1'b1; step();
      chk("clr_drop0", 32'(drop0), 0);
      chk("clr_drop1", 32'(drop1), 0);
      chk("clr_ovf",   32'(ovf0 | ovf1), 0);
      clear = 1'b0; spikes = 8'h00; ready = 1'b1;
      repeat (10) step();

      // randomized traffic with backpressure, stat clears and rare resets
      for (int c = 0; c < 600; c++) begin
         spikes = 8'($urandom) & 8'($urandom) & 8'($urandom);
         ready  = ($urandom_range(0, 3) != 0);
         clear  = ($urandom_range(0, 40) == 0);
         rst    = ($urandom_range(0, 150) == 0);
         step();
      end
      rst = 1'b0; clear = 1'b0; spikes = 8'h00;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
